// File: rtl/regfile_access_ctrl.sv
`timescale 1ns/1ps
// Round-robin access controller for the shared single port of the 8x32 register file.
// One read or write every three cycles, plus a clear command; write enable launched on the falling edge.
module regfile_access_ctrl #(
   parameter int DW = 32,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          CLRn,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   input  logic          clr_req,
   output logic          clr_done,
   output logic          busy,
   output logic [AW-1:0] rf_Addr,
   output logic [DW-1:0] rf_DataIn,
   output logic          rf_regWE,
   output logic          rf_CLR,
   input  logic [DW-1:0] rf_DataOut
);

   typedef enum logic [2:0] {IDLE, WR, RD, ACK, CLRS} state_t;

   state_t state, state_nxt;
   logic   owner_b;
   logic   last_b;
   logic   grant, grant_b, grant_we;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_b  = b_req && (!a_req || !last_b);
      grant    = !clr_req && (a_req || b_req);
      grant_we = grant_b ? b_we : a_we;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (clr_req)    state_nxt = CLRS;
            else if (grant) state_nxt = grant_we ? WR : RD;
         end
         WR:      state_nxt = ACK;
         RD:      state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         CLRS:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge CLRn) begin
      if (!CLRn) begin
         state     <= IDLE;
         owner_b   <= 1'b0;
         last_b    <= 1'b1;
         rf_Addr   <= '0;
         rf_DataIn <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && grant) begin
            owner_b   <= grant_b;
            last_b    <= grant_b;
            rf_Addr   <= grant_b ? b_addr : a_addr;
            rf_DataIn <= grant_b ? b_wdata : a_wdata;
         end
      end
   end

   // Read data is captured at the edge leaving RD, into the owner's register only.
   always_ff @(posedge clk or negedge CLRn) begin
      if (!CLRn) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else if (state == RD) begin
         if (owner_b) b_rdata <= rf_DataOut;
         else         a_rdata <= rf_DataOut;
      end
   end

   // Falling-edge launch keeps regWE stable across the rising edge that clocks the register file.
   always_ff @(negedge clk or negedge CLRn) begin
      if (!CLRn) rf_regWE <= 1'b0;
      else       rf_regWE <= (state == WR);
   end

   assign a_ack    = (state == ACK) && !owner_b;
   assign b_ack    = (state == ACK) && owner_b;
   assign rf_CLR   = (state == CLRS);
   assign clr_done = (state == CLRS);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_regfile_access_ctrl.sv
`timescale 1ns/1ps
// Directed bench for regfile_access_ctrl with a behavioural 8x32 register file attached.
module tb_regfile_access_ctrl;

   logic        clk = 1'b0;
   logic        CLRn;
   logic        a_req, a_we, b_req, b_we, clr_req;
   logic [2:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_ack, b_ack, clr_done, busy, rf_regWE, rf_CLR;
   logic [31:0] a_rdata, b_rdata, rf_DataIn, rf_DataOut;
   logic [2:0]  rf_Addr;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [8] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
                             32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};

   always #5 clk = ~clk;

   // Register file: writes on the gated clock (clk qualified by regWE), combinational read.
   always @(posedge clk) begin
      if (rf_CLR) begin
         for (int k = 0; k < 8; k++) mem[k] <= 32'h0;
      end else if (rf_regWE) begin
         mem[rf_Addr] <= rf_DataIn;
      end
   end
   assign rf_DataOut = mem[rf_Addr];

   regfile_access_ctrl #(.DW(32), .AW(3)) dut (
      .clk(clk), .CLRn(CLRn),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
      .rf_Addr(rf_Addr), .rf_DataIn(rf_DataIn), .rf_regWE(rf_regWE),
      .rf_CLR(rf_CLR), .rf_DataOut(rf_DataOut)
   );

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[7];

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One A operation from an IDLE cycle; checks regWE phase, ack cycle and read data.
   task automatic op_a(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp, input string nm);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
      tick();
      chk1({nm, "_busy1"}, busy, 1'b1);
      chk1({nm, "_ack1"}, a_ack, 1'b0);
      chk1({nm, "_we1a"}, rf_regWE, 1'b0);
      chk32({nm, "_addr1"}, {29'b0, rf_Addr}, {29'b0, addr});
      @(negedge clk); #1;
      chk1({nm, "_we1b"}, rf_regWE, we);
      tick();
      chk1({nm, "_ack2"}, a_ack, 1'b1);
      chk1({nm, "_back2"}, b_ack, 1'b0);
      chk1({nm, "_we2a"}, rf_regWE, we);
      if (!we) chk32({nm, "_rdata"}, a_rdata, exp);
      a_req = 1'b0;
      @(negedge clk); #1;
      chk1({nm, "_we2b"}, rf_regWE, 1'b0);
      tick();
      chk1({nm, "_busy3"}, busy, 1'b0);
      chk1({nm, "_ack3"}, a_ack, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0] ack_mask;
      logic [12:0] exp_mask;
      int          n_ack;

      vecs[0] = '{1'b1, 3'd5, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b0, 3'd5, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{1'b1, 3'd2, 32'h12345678, 32'h0};
      vecs[3] = '{1'b0, 3'd2, 32'h0,        32'h12345678};
      vecs[4] = '{1'b0, 3'd5, 32'h0,        32'hDEADBEEF};
      vecs[5] = '{1'b1, 3'd0, 32'hFFFFFFFF, 32'h0};
      vecs[6] = '{1'b0, 3'd0, 32'h0,        32'hFFFFFFFF};

      // T1: reset with random inputs
      CLRn = 1'b0;
      repeat (3) begin
         a_req = 1'($urandom); a_we = 1'($urandom); a_addr = 3'($urandom); a_wdata = $urandom;
         b_req = 1'($urandom); b_we = 1'($urandom); b_addr = 3'($urandom); b_wdata = $urandom;
         clr_req = 1'($urandom);
         tick();
      end
      @(negedge clk); #1;
      chk1("rst_a_ack", a_ack, 1'b0);
      chk1("rst_b_ack", b_ack, 1'b0);
      chk1("rst_clr_done", clr_done, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_regwe", rf_regWE, 1'b0);
      chk1("rst_clr", rf_CLR, 1'b0);
      chk32("rst_a_rdata", a_rdata, 32'h0);
      chk32("rst_b_rdata", b_rdata, 32'h0);
      chk32("rst_addr", {29'b0, rf_Addr}, 32'h0);
      chk32("rst_datain", rf_DataIn, 32'h0);
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      clr_req = 1'b0;
      tick();
      CLRn = 1'b1;
      tick();
      chk1("rel_busy", busy, 1'b0);

      // T2: table of A operations
      for (int i = 0; i < 7; i++)
         op_a(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp, $sformatf("vec%0d", i));

      // T3: simultaneous writes from reset, A first then B
      CLRn = 1'b0; #1; CLRn = 1'b1;
      tick();
      a_req = 1'b1; a_we = 1'b1; a_addr = 3'd3; a_wdata = 32'h11;
      b_req = 1'b1; b_we = 1'b1; b_addr = 3'd3; b_wdata = 32'h22;
      tick();
      chk32("t3_din_a", rf_DataIn, 32'h11);
      tick();
      chk1("t3_a_ack2", a_ack, 1'b1);
      chk1("t3_b_ack2", b_ack, 1'b0);
      a_req = 1'b0;
      tick();
      chk1("t3_busy3", busy, 1'b0);
      tick();
      chk32("t3_din_b", rf_DataIn, 32'h22);
      chk1("t3_a_ack4", a_ack, 1'b0);
      tick();
      chk1("t3_b_ack5", b_ack, 1'b1);
      chk1("t3_a_ack5", a_ack, 1'b0);
      b_req = 1'b0;
      tick();
      op_a(1'b0, 3'd3, 32'h0, 32'h22, "t3_rd3");
      // A was served last, so B wins the next tie
      a_req = 1'b1; a_we = 1'b0; a_addr = 3'd5;
      b_req = 1'b1; b_we = 1'b0; b_addr = 3'd3;
      tick();
      tick();
      chk1("t3_rr_b_ack", b_ack, 1'b1);
      chk1("t3_rr_a_ack", a_ack, 1'b0);
      chk32("t3_rr_b_rdata", b_rdata, 32'h22);
      b_req = 1'b0;
      tick();
      tick();
      tick();
      chk1("t3_rr_a_ack5", a_ack, 1'b1);
      chk32("t3_rr_a_rdata", a_rdata, 32'hDEADBEEF);
      chk32("t3_rr_b_hold", b_rdata, 32'h22);
      a_req = 1'b0;
      tick();

      // T4: clear has priority over a simultaneous write
      clr_req = 1'b1;
      a_req = 1'b1; a_we = 1'b1; a_addr = 3'd7; a_wdata = 32'h5A;
      tick();
      chk1("t4_clr", rf_CLR, 1'b1);
      chk1("t4_done", clr_done, 1'b1);
      chk1("t4_noack", a_ack, 1'b0);
      clr_req = 1'b0;
      tick();
      chk1("t4_clr_off", rf_CLR, 1'b0);
      chk1("t4_done_off", clr_done, 1'b0);
      chk1("t4_idle", busy, 1'b0);
      tick();
      tick();
      chk1("t4_a_ack", a_ack, 1'b1);
      a_req = 1'b0;
      tick();
      for (int r = 0; r < 8; r++)
         op_a(1'b0, 3'(r), 32'h0, (r == 7) ? 32'h5A : 32'h0, $sformatf("t4_rd%0d", r));

      // T5: reset asserted in the second half of WR
      a_req = 1'b1; a_we = 1'b1; a_addr = 3'd1; a_wdata = 32'h77;
      tick();
      @(negedge clk); #1;
      chk1("t5_we_hi", rf_regWE, 1'b1);
      #1 CLRn = 1'b0;
      #1;
      chk1("t5_we_drop", rf_regWE, 1'b0);
      chk1("t5_busy_rst", busy, 1'b0);
      a_req = 1'b0;
      #1 CLRn = 1'b1;
      tick();
      chk1("t5_noack1", a_ack, 1'b0);
      chk1("t5_idle", busy, 1'b0);
      tick();
      chk1("t5_noack2", a_ack, 1'b0);
      op_a(1'b0, 3'd7, 32'h0, 32'h5A, "t5_rd7");
      op_a(1'b0, 3'd1, 32'h0, 32'h0, "t5_rd1");

      // T6: A holds req through its acks, four back-to-back reads
      ack_mask = '0;
      n_ack = 0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 3'd7;
      for (int c = 1; c <= 12; c++) begin
         tick();
         ack_mask[c] = a_ack;
         if (a_ack) n_ack++;
         if (c == 11) a_req = 1'b0;
      end
      exp_mask = 13'h924;
      chk32("t6_ack_mask", {19'b0, ack_mask}, {19'b0, exp_mask});
      chk32("t6_n_ack", n_ack, 32'd4);
      chk32("t6_rdata", a_rdata, 32'h5A);
      chk1("t6_idle12", busy, 1'b0);
      tick();
      chk1("t6_idle13", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
